// File: rtl/sata_rx_prim_decoder.sv
// SATA receive link-layer front end: strips ALIGN, decodes primitives, expands CONTp,
// tracks SOF..EOF framing and delivers payload dwords, all through one register stage.
module sata_rx_prim_decoder #(
    parameter int MAX_DWORDS = 8194,
    parameter int LEN_W      = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             linkup,
    input  logic [31:0]      rx_datain,
    input  logic [3:0]       rx_charisk_in,
    output logic [3:0]       prim_code,
    output logic             prim_valid,
    output logic [31:0]      data_out,
    output logic             data_valid,
    output logic             sof_pulse,
    output logic             eof_pulse,
    output logic             frame_active,
    output logic [LEN_W-1:0] frame_len,
    output logic             err_unknown_prim,
    output logic             err_bad_cont,
    output logic             err_frame_long,
    output logic             frame_abort
);

    typedef enum logic [3:0] {
        P_NONE    = 4'd0,
        P_SYNC    = 4'd1,
        P_X_RDY   = 4'd2,
        P_R_RDY   = 4'd3,
        P_R_IP    = 4'd4,
        P_R_OK    = 4'd5,
        P_R_ERR   = 4'd6,
        P_SOF     = 4'd7,
        P_EOF     = 4'd8,
        P_HOLD    = 4'd9,
        P_HOLDA   = 4'd10,
        P_WTRM    = 4'd11,
        P_DMAT    = 4'd12,
        P_UNKNOWN = 4'd15
    } prim_e;

    typedef enum logic [1:0] {S_IDLE, S_PRIM, S_CONT} state_e;
    typedef enum logic [2:0] {D_DATA, D_ALIGN, D_CONT, D_PRIM, D_UNKNOWN} kind_e;

    localparam logic [LEN_W:0] LONG_MARK = (LEN_W+1)'(MAX_DWORDS + 1);

    state_e           state_q, state_d;
    prim_e            last_q, last_d;
    logic             long_seen_q, long_seen_d;
    kind_e            kind;
    prim_e            dec_code;
    logic             in_cont;
    logic [LEN_W:0]   len_inc;

    logic [3:0]       code_d;
    logic             pvalid_d, dvalid_d, sof_d, eof_d, active_d;
    logic             unk_d, bad_d, long_d, abort_d;
    logic [31:0]      dout_d;
    logic [LEN_W-1:0] len_d;

    // Full-word match implies the byte0 check: only BC (ALIGN) and 7C words are listed.
    always_comb begin
        kind     = D_UNKNOWN;
        dec_code = P_UNKNOWN;
        if (rx_charisk_in == 4'b0000) begin
            kind = D_DATA;
        end else if (rx_charisk_in == 4'b0001) begin
            kind = D_PRIM;
            case (rx_datain)
                32'h7B4A4ABC: kind     = D_ALIGN;
                32'h9999AA7C: kind     = D_CONT;
                32'hB5B5957C: dec_code = P_SYNC;
                32'h5757B57C: dec_code = P_X_RDY;
                32'h4A4A957C: dec_code = P_R_RDY;
                32'h5555B57C: dec_code = P_R_IP;
                32'h3535B57C: dec_code = P_R_OK;
                32'h5656B57C: dec_code = P_R_ERR;
                32'h3737B57C: dec_code = P_SOF;
                32'hD5D5B57C: dec_code = P_EOF;
                32'hD5D5AA7C: dec_code = P_HOLD;
                32'h9595AA7C: dec_code = P_HOLDA;
                32'h5858B57C: dec_code = P_WTRM;
                32'h3636B57C: dec_code = P_DMAT;
                default:      kind     = D_UNKNOWN;
            endcase
        end
    end

    assign in_cont = (state_q == S_CONT);
    assign len_inc = {1'b0, frame_len} + (LEN_W+1)'(1);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        long_seen_d = long_seen_q;
        code_d      = prim_code;
        pvalid_d    = 1'b0;
        dout_d      = data_out;
        dvalid_d    = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        active_d    = frame_active;
        len_d       = frame_len;
        unk_d       = 1'b0;
        bad_d       = 1'b0;
        long_d      = 1'b0;
        abort_d     = 1'b0;

        if (!linkup) begin
            state_d     = S_IDLE;
            last_d      = P_NONE;
            long_seen_d = 1'b0;
            code_d      = P_NONE;
            dout_d      = '0;
            active_d    = 1'b0;
            len_d       = '0;
            abort_d     = frame_active;
        end else begin
            state_d = in_cont ? S_CONT : S_PRIM;
            case (kind)
                D_ALIGN: begin
                    if (in_cont) begin
                        pvalid_d = 1'b1;
                        code_d   = last_q;
                    end
                end
                D_DATA: begin
                    if (in_cont) begin
                        // Scrambled filler between CONT and the next primitive.
                        pvalid_d = 1'b1;
                        code_d   = last_q;
                    end else if (frame_active) begin
                        dvalid_d = 1'b1;
                        dout_d   = rx_datain;
                        if (frame_len != '1)
                            len_d = len_inc[LEN_W-1:0];
                        if (len_inc == LONG_MARK && !long_seen_q) begin
                            long_d      = 1'b1;
                            long_seen_d = 1'b1;
                        end
                    end
                end
                D_CONT: begin
                    if (in_cont || !(last_q inside {P_NONE, P_SOF, P_EOF, P_UNKNOWN})) begin
                        state_d  = S_CONT;
                        pvalid_d = 1'b1;
                        code_d   = last_q;
                    end else begin
                        state_d = S_PRIM;
                        bad_d   = 1'b1;
                    end
                end
                D_UNKNOWN: begin
                    state_d  = S_PRIM;
                    last_d   = P_UNKNOWN;
                    code_d   = P_UNKNOWN;
                    pvalid_d = 1'b1;
                    unk_d    = 1'b1;
                end
                default: begin
                    state_d  = S_PRIM;
                    last_d   = dec_code;
                    code_d   = dec_code;
                    pvalid_d = 1'b1;
                    if (dec_code == P_SOF) begin
                        active_d    = 1'b1;
                        len_d       = '0;
                        long_seen_d = 1'b0;
                        sof_d       = 1'b1;
                    end else if (dec_code == P_EOF && frame_active) begin
                        active_d = 1'b0;
                        eof_d    = 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            last_q           <= P_NONE;
            long_seen_q      <= 1'b0;
            prim_code        <= '0;
            prim_valid       <= 1'b0;
            data_out         <= '0;
            data_valid       <= 1'b0;
            sof_pulse        <= 1'b0;
            eof_pulse        <= 1'b0;
            frame_active     <= 1'b0;
            frame_len        <= '0;
            err_unknown_prim <= 1'b0;
            err_bad_cont     <= 1'b0;
            err_frame_long   <= 1'b0;
            frame_abort      <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_q           <= last_d;
            long_seen_q      <= long_seen_d;
            prim_code        <= code_d;
            prim_valid       <= pvalid_d;
            data_out         <= dout_d;
            data_valid       <= dvalid_d;
            sof_pulse        <= sof_d;
            eof_pulse        <= eof_d;
            frame_active     <= active_d;
            frame_len        <= len_d;
            err_unknown_prim <= unk_d;
            err_bad_cont     <= bad_d;
            err_frame_long   <= long_d;
            frame_abort      <= abort_d;
        end
    end

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// Directed bench for sata_rx_prim_decoder with MAX_DWORDS = 8 and a 4-bit length counter,
// so the long-frame pulse and length saturation are both reachable in a few dwords.
module tb_sata_rx_prim_decoder;

    localparam int LEN_W = 4;

    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam logic [31:0] CONT  = 32'h9999AA7C;
    localparam logic [31:0] X_RDY = 32'h5757B57C;
    localparam logic [31:0] R_OK  = 32'h3535B57C;
    localparam logic [31:0] SOF   = 32'h3737B57C;
    localparam logic [31:0] EOF   = 32'hD5D5B57C;
    localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] HOLDA = 32'h9595AA7C;
    localparam logic [3:0]  KP    = 4'b0001;
    localparam logic [3:0]  KD    = 4'b0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             linkup;
    logic [31:0]      rx_datain;
    logic [3:0]       rx_charisk_in;
    logic [3:0]       prim_code;
    logic             prim_valid;
    logic [31:0]      data_out;
    logic             data_valid;
    logic             sof_pulse;
    logic             eof_pulse;
    logic             frame_active;
    logic [LEN_W-1:0] frame_len;
    logic             err_unknown_prim;
    logic             err_bad_cont;
    logic             err_frame_long;
    logic             frame_abort;

    logic [48:0] all_out;
    int          n_cmp = 0;
    int          n_err = 0;
    int          long_cnt;

    assign all_out = {prim_code, prim_valid, data_out, data_valid, sof_pulse, eof_pulse,
                      frame_active, frame_len, err_unknown_prim, err_bad_cont,
                      err_frame_long, frame_abort};

    sata_rx_prim_decoder #(.MAX_DWORDS(8), .LEN_W(LEN_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .linkup           (linkup),
        .rx_datain        (rx_datain),
        .rx_charisk_in    (rx_charisk_in),
        .prim_code        (prim_code),
        .prim_valid       (prim_valid),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .sof_pulse        (sof_pulse),
        .eof_pulse        (eof_pulse),
        .frame_active     (frame_active),
        .frame_len        (frame_len),
        .err_unknown_prim (err_unknown_prim),
        .err_bad_cont     (err_bad_cont),
        .err_frame_long   (err_frame_long),
        .frame_abort      (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one dword from a falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic [31:0] d, input logic [3:0] k);
        rx_datain     = d;
        rx_charisk_in = k;
        @(negedge clk);
    endtask

    task automatic check_prim(input string tag, input logic [3:0] code);
        check({tag, "_valid"}, prim_valid, 1'b1);
        check({tag, "_code"}, prim_code, code);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; linkup = 1'b0; rx_datain = '0; rx_charisk_in = KD;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_out, '0);

        // Link comes up; a filler data dword outside a frame is discarded.
        reset = 1'b1; linkup = 1'b1;
        step(32'h0, KD);
        check("filler_dv", data_valid, 1'b0);
        step(SYNC, KP);  check_prim("sync1", 4'd1);
        step(ALIGN, KP); check("align_pv", prim_valid, 1'b0);
        check("align_dv", data_valid, 1'b0);
        step(SYNC, KP);  check_prim("sync3", 4'd1);
        check("no_errs", {err_unknown_prim, err_bad_cont, err_frame_long, frame_abort}, 4'b0);

        // CONT expansion: X_RDY held through junk and ALIGN.
        step(X_RDY, KP); check_prim("xrdy", 4'd2);
        step(CONT, KP);  check_prim("xrdy_cont", 4'd2);
        for (int i = 0; i < 5; i++) begin
            step(32'hA5A50000 + 32'(i * 7919), KD);
            check_prim("xrdy_junk", 4'd2);
            check("xrdy_junk_dv", data_valid, 1'b0);
        end
        step(ALIGN, KP); check_prim("xrdy_align", 4'd2);
        step(R_OK, KP);  check_prim("rok", 4'd5);

        // Frame with HOLD/CONT in the middle.
        step(SOF, KP);
        check("sof_pulse", sof_pulse, 1'b1);
        check("sof_active", frame_active, 1'b1);
        check_prim("sof", 4'd7);
        for (int i = 1; i <= 4; i++) begin
            step(32'h11111111 * 32'(i), KD);
            check("f1_dv", data_valid, 1'b1);
            check("f1_data", data_out, 32'h11111111 * 32'(i));
            check("f1_pv", prim_valid, 1'b0);
        end
        check("f1_len4", frame_len, 4'd4);
        step(HOLD, KP);  check_prim("hold", 4'd9);
        step(CONT, KP);  check_prim("hold_cont", 4'd9);
        step(32'hDEAD0001, KD); check_prim("hold_junk1", 4'd9);
        check("hold_junk1_dv", data_valid, 1'b0);
        step(32'hDEAD0002, KD); check_prim("hold_junk2", 4'd9);
        check("hold_len", frame_len, 4'd4);
        step(HOLDA, KP); check_prim("holda", 4'd10);
        step(32'h55555555, KD);
        check("f1_d5", {data_valid, data_out}, {1'b1, 32'h55555555});
        step(32'h66666666, KD);
        check("f1_d6", {data_valid, data_out}, {1'b1, 32'h66666666});
        step(EOF, KP);
        check("eof_pulse", eof_pulse, 1'b1);
        check("eof_inactive", frame_active, 1'b0);
        check("f1_len", frame_len, 4'd6);

        // Illegal CONT right after linkup and right after SOF; state must stay PRIM.
        linkup = 1'b0; step(32'h0, KD);
        check("down_idle_abort", frame_abort, 1'b0);
        linkup = 1'b1;
        step(CONT, KP);
        check("badcont1", err_bad_cont, 1'b1);
        check("badcont1_pv", prim_valid, 1'b0);
        step(SOF, KP);
        check("badcont_sof", sof_pulse, 1'b1);
        step(CONT, KP);
        check("badcont2", err_bad_cont, 1'b1);
        step(32'h12121212, KD);
        check("badcont_prim_dv", data_valid, 1'b1);
        step(EOF, KP);
        check("badcont_len", frame_len, 4'd1);

        // Long frame: 10 dwords with limit 8, pulse on the 9th only.
        step(SOF, KP);
        for (int i = 0; i < 10; i++) begin
            step(32'(i), KD);
            check("long_dv", data_valid, 1'b1);
            check("long_pulse", err_frame_long, i == 8);
        end
        step(EOF, KP);
        check("long_len", frame_len, 4'd10);

        // Saturation: 17 dwords clamp frame_len at 15, one long pulse for the new frame.
        step(SOF, KP);
        long_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            step(32'hF0000000 + 32'(i), KD);
            if (err_frame_long) long_cnt++;
        end
        check("sat_len", frame_len, 4'd15);
        check("sat_long_cnt", long_cnt, 1);
        step(EOF, KP);
        check("sat_eof", {eof_pulse, frame_len}, {1'b1, 4'd15});

        // Link drop mid-frame.
        step(SOF, KP);
        for (int i = 0; i < 3; i++) step(32'hCAFE0000 + 32'(i), KD);
        check("abort_pre_len", frame_len, 4'd3);
        linkup = 1'b0;
        step(SYNC, KP);
        check("abort_pulse", frame_abort, 1'b1);
        check("abort_active", frame_active, 1'b0);
        check("abort_pv", prim_valid, 1'b0);
        step(SYNC, KP);
        check("abort_all_zero", all_out, '0);

        // Unknown primitives: bad K pattern, and an unmatched 7C word inside CONT.
        linkup = 1'b1;
        step(32'h12345678, 4'b0011);
        check("unk_k", err_unknown_prim, 1'b1);
        check_prim("unk_k", 4'd15);
        step(SYNC, KP);
        step(CONT, KP);  check_prim("sync_cont", 4'd1);
        step(32'hDEADBE7C, KP);
        check("unk_word", err_unknown_prim, 1'b1);
        check_prim("unk_word", 4'd15);
        step(32'h77777777, KD);
        check("unk_exit_cont", prim_valid, 1'b0);
        step(CONT, KP);
        check("unk_badcont", err_bad_cont, 1'b1);
        step(EOF, KP);
        check_prim("eof_idle", 4'd8);
        check("eof_idle_pulse", eof_pulse, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
